cl_ocl_reg_bank: RTL and testbench

// - Parametrised AXI-Lite register bank on the OCL (AppPF BAR0) path, behind the OCL register slice, on clk_main_a0.
// - NUM_REGS 32-bit registers with byte strobes, independent AW/W acceptance, read-only status registers and per-register ASCII upper-case read view.
// - Decode errors are returned in the response.
// - Drives the virtual-LED output, masked by the virtual DIP switches.

---
 rtl/cl_ocl_reg_pkg.sv | 27 ++
 rtl/cl_ocl_axil_wr_join.sv | 73 +++++++
 rtl/cl_ocl_reg_bank.sv | 211 +++++++++++++++++++++
 tb/tb_cl_ocl_reg_bank.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_ocl_reg_pkg.sv
// Shared types and helpers for the OCL AXI-Lite register bank.
package cl_ocl_reg_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_t;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Per-byte ASCII lower-to-upper case fold; non-letters pass through.
  function automatic logic [31:0] to_upper32(input logic [31:0] d);
    logic [31:0] r;
    logic [7:0]  c;
    r = d;
    for (int b = 0; b < 4; b++) begin
      c = d[8*b +: 8];
      if ((c >= 8'h61) && (c <= 8'h7A)) r[8*b +: 8] = c - 8'h20;
      else                               r[8*b +: 8] = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/cl_ocl_axil_wr_join.sv
// AXI-Lite write join: one AW slot, one W slot, commit when both are full, B response.
module cl_ocl_axil_wr_join
  import cl_ocl_reg_pkg::*;
(
  input  logic        clk_main_a0,
  input  logic        rst_main_sync,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  axil_resp_t  commit_resp,
  output logic        commit,
  output logic [31:0] commit_addr,
  output logic [31:0] commit_data,
  output logic [3:0]  commit_strb
);

  logic        aw_full_r;
  logic [31:0] aw_addr_r;
  logic        w_full_r;
  logic [31:0] w_data_r;
  logic [3:0]  w_strb_r;
  logic        bvalid_r;
  axil_resp_t  bresp_r;

  assign awready     = !aw_full_r && !bvalid_r;
  assign wready      = !w_full_r && !bvalid_r;
  assign commit      = aw_full_r && w_full_r;
  assign commit_addr = aw_addr_r;
  assign commit_data = w_data_r;
  assign commit_strb = w_strb_r;
  assign bvalid      = bvalid_r;
  assign bresp       = bresp_r;

  // Slot capture, commit and B response; slots stay closed while B is outstanding.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      aw_full_r <= 1'b0;
      aw_addr_r <= 32'h0;
      w_full_r  <= 1'b0;
      w_data_r  <= 32'h0;
      w_strb_r  <= 4'h0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else if (commit) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      bvalid_r  <= 1'b1;
      bresp_r   <= commit_resp;
    end else begin
      if (awvalid && awready) begin
        aw_full_r <= 1'b1;
        aw_addr_r <= awaddr;
      end
      if (wvalid && wready) begin
        w_full_r <= 1'b1;
        w_data_r <= wdata;
        w_strb_r <= wstrb;
      end
      if (bvalid_r && bready) begin
        bvalid_r <= 1'b0;
        bresp_r  <= RESP_OKAY;
      end
    end
  end

endmodule

// File: rtl/cl_ocl_reg_bank.sv
// AXI-Lite register bank on the OCL path: RW/RO registers with byte strobes,
// optional upper-case read view, decode errors in the response, and the virtual-LED drive.
module cl_ocl_reg_bank
  import cl_ocl_reg_pkg::*;
#(
  parameter int unsigned          NUM_REGS     = 8,
  parameter logic [31:0]          BASE_ADDR    = 32'h0000_0500,
  parameter logic [NUM_REGS-1:0]  RO_MASK      = '0,
  parameter logic [NUM_REGS-1:0]  UPPER_MASK   = '0,
  parameter int unsigned          VLED_IDX     = 1,
  parameter logic [31:0]          UNIMPL_VALUE = 32'hDEAD_BEEF
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main_sync,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [31:0]              araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  input  logic [NUM_REGS*32-1:0]   reg_in,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse,
  input  logic [15:0]              sh_cl_status_vdip,
  output logic [15:0]              cl_sh_status_vled
);

  localparam int IDX_W = idx_width(NUM_REGS);

  function automatic logic dec_err(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || (addr[1:0] != 2'b00) || ({2'b00, off[31:2]} >= NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] dec_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  logic             commit_s;
  logic [31:0]      commit_addr_s;
  logic [31:0]      commit_data_s;
  logic [3:0]       commit_strb_s;
  logic             commit_err_s;
  logic [IDX_W-1:0] commit_idx_s;
  axil_resp_t       commit_resp_s;
  logic             commit_ok_s;
  logic [31:0]      reg_rd_s [NUM_REGS];

  cl_ocl_axil_wr_join u_wr_join (
    .clk_main_a0   (clk_main_a0),
    .rst_main_sync (rst_main_sync),
    .awvalid       (awvalid),
    .awready       (awready),
    .awaddr        (awaddr),
    .wvalid        (wvalid),
    .wready        (wready),
    .wdata         (wdata),
    .wstrb         (wstrb),
    .bvalid        (bvalid),
    .bready        (bready),
    .bresp         (bresp),
    .commit_resp   (commit_resp_s),
    .commit        (commit_s),
    .commit_addr   (commit_addr_s),
    .commit_data   (commit_data_s),
    .commit_strb   (commit_strb_s)
  );

  assign commit_err_s = dec_err(commit_addr_s);
  assign commit_idx_s = dec_idx(commit_addr_s);

  // Write response classification for the pending commit.
  always_comb begin
    commit_resp_s = RESP_OKAY;
    if (commit_err_s)               commit_resp_s = RESP_DECERR;
    else if (RO_MASK[commit_idx_s]) commit_resp_s = RESP_SLVERR;
    else                            commit_resp_s = RESP_OKAY;
  end

  assign commit_ok_s = commit_s && (commit_resp_s == RESP_OKAY);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_rd_s[gi]         = reg_in[gi*32 +: 32];
      assign reg_q[gi*32 +: 32]   = 32'h0;
      assign wr_pulse[gi]         = 1'b0;
    end else begin : g_rw
      logic [31:0] reg_r;
      logic        pulse_r;
      logic        hit_s;
      logic        unused_in_s;

      assign unused_in_s = ^reg_in[gi*32 +: 32];
      assign hit_s       = commit_ok_s && (commit_idx_s == IDX_W'(gi));

      // Byte-strobed register update and write-commit pulse.
      always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
          reg_r   <= 32'h0;
          pulse_r <= 1'b0;
        end else begin
          pulse_r <= hit_s && (commit_strb_s != 4'b0000);
          for (int b = 0; b < 4; b++) begin
            if (hit_s && commit_strb_s[b]) reg_r[8*b +: 8] <= commit_data_s[8*b +: 8];
          end
        end
      end

      assign reg_rd_s[gi]       = reg_r;
      assign reg_q[gi*32 +: 32] = reg_r;
      assign wr_pulse[gi]       = pulse_r;
    end
  end

  logic             ar_pend_r;
  logic [31:0]      ar_addr_r;
  logic             rvalid_r;
  logic [31:0]      rdata_r;
  logic [1:0]       rresp_r;
  logic             rd_err_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [31:0]      rd_raw_s;
  logic [31:0]      rd_data_s;
  logic [1:0]       rd_resp_s;

  assign arready  = !rvalid_r && !ar_pend_r;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign rresp    = rresp_r;
  assign rd_err_s = dec_err(ar_addr_r);
  assign rd_idx_s = dec_idx(ar_addr_r);

  // Read data selection, including the upper-case view and decode-error value.
  always_comb begin
    rd_raw_s  = reg_rd_s[rd_idx_s];
    rd_data_s = rd_raw_s;
    rd_resp_s = RESP_OKAY;
    if (rd_err_s) begin
      rd_data_s = UNIMPL_VALUE;
      rd_resp_s = RESP_DECERR;
    end else if (UPPER_MASK[rd_idx_s]) begin
      rd_data_s = to_upper32(rd_raw_s);
      rd_resp_s = RESP_OKAY;
    end else begin
      rd_data_s = rd_raw_s;
      rd_resp_s = RESP_OKAY;
    end
  end

  // AR capture, one-cycle data load and R handshake.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      ar_pend_r <= 1'b0;
      ar_addr_r <= 32'h0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0;
      rresp_r   <= 2'b00;
    end else if (ar_pend_r) begin
      ar_pend_r <= 1'b0;
      rvalid_r  <= 1'b1;
      rdata_r   <= rd_data_s;
      rresp_r   <= rd_resp_s;
    end else if (rvalid_r && rready) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0;
      rresp_r  <= 2'b00;
    end else if (arvalid && arready) begin
      ar_pend_r <= 1'b1;
      ar_addr_r <= araddr;
    end
  end

  logic [15:0] vdip_q1_r;
  logic [15:0] vdip_q2_r;
  logic [15:0] vled_r;
  logic [31:0] vled_src_s;

  assign vled_src_s        = reg_rd_s[VLED_IDX];
  assign cl_sh_status_vled = vled_r;

  // DIP synchroniser and masked LED register.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      vdip_q1_r <= 16'h0;
      vdip_q2_r <= 16'h0;
      vled_r    <= 16'h0;
    end else begin
      vdip_q1_r <= sh_cl_status_vdip;
      vdip_q2_r <= vdip_q1_r;
      vled_r    <= vled_src_s[15:0] & vdip_q2_r;
    end
  end

  logic unused_vled_s;
  assign unused_vled_s = ^vled_src_s[31:16];

endmodule

// File: tb/tb_cl_ocl_reg_bank.sv
// Directed bench for cl_ocl_reg_bank: a default instance and one with RO reg 2 and upper-case reg 0.
module tb_cl_ocl_reg_bank;

  logic         clk_main_a0 = 1'b0;
  logic         rst_main_sync;
  logic         awvalid;
  logic [31:0]  awaddr;
  logic         wvalid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         bready;
  logic         arvalid;
  logic [31:0]  araddr;
  logic         rready;
  logic [255:0] reg_in;
  logic [15:0]  vdip;

  logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]   a_bresp, a_rresp;
  logic [31:0]  a_rdata;
  logic [255:0] a_reg_q;
  logic [7:0]   a_wr_pulse;
  logic [15:0]  a_vled;
  logic         b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]   b_bresp, b_rresp;
  logic [31:0]  b_rdata;
  logic [255:0] b_reg_q;
  logic [7:0]   b_wr_pulse;
  logic [15:0]  b_vled;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  rr_a, rr_b, br_a, br_b;
  logic [7:0]  wp_a;

  always #5 clk_main_a0 = ~clk_main_a0;

  cl_ocl_reg_bank u_dut_a (
    .clk_main_a0(clk_main_a0), .rst_main_sync(rst_main_sync),
    .awvalid(awvalid), .awready(a_awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(a_wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(a_bvalid), .bready(bready), .bresp(a_bresp),
    .arvalid(arvalid), .arready(a_arready), .araddr(araddr),
    .rvalid(a_rvalid), .rready(rready), .rdata(a_rdata), .rresp(a_rresp),
    .reg_in(reg_in), .reg_q(a_reg_q), .wr_pulse(a_wr_pulse),
    .sh_cl_status_vdip(vdip), .cl_sh_status_vled(a_vled)
  );

  cl_ocl_reg_bank #(.RO_MASK(8'h04), .UPPER_MASK(8'h01)) u_dut_b (
    .clk_main_a0(clk_main_a0), .rst_main_sync(rst_main_sync),
    .awvalid(awvalid), .awready(b_awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(b_wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(b_bvalid), .bready(bready), .bresp(b_bresp),
    .arvalid(arvalid), .arready(b_arready), .araddr(araddr),
    .rvalid(b_rvalid), .rready(rready), .rdata(b_rdata), .rresp(b_rresp),
    .reg_in(reg_in), .reg_q(b_reg_q), .wr_pulse(b_wr_pulse),
    .sh_cl_status_vdip(vdip), .cl_sh_status_vled(b_vled)
  );

  task automatic step;
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr);
    chk("arready_pre", a_arready, 64'd1);
    arvalid = 1'b1;
    araddr  = addr;
    step;
    arvalid = 1'b0;
    chk("rvalid_lat0", a_rvalid, 64'd0);
    step;
    chk("rvalid_lat1", a_rvalid, 64'd1);
    rd_a = a_rdata;
    rd_b = b_rdata;
    rr_a = a_rresp;
    rr_b = b_rresp;
    step;
    chk("rvalid_clr", a_rvalid, 64'd0);
    chk("rdata_clr", a_rdata, 64'd0);
  endtask

  task automatic do_write_same(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    chk("awready_pre", a_awready, 64'd1);
    chk("wready_pre", a_wready, 64'd1);
    awvalid = 1'b1;
    awaddr  = addr;
    wvalid  = 1'b1;
    wdata   = data;
    wstrb   = strb;
    step;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("bvalid_early", a_bvalid, 64'd0);
    step;
    chk("bvalid_rise", a_bvalid, 64'd1);
    br_a = a_bresp;
    br_b = b_bresp;
    wp_a = a_wr_pulse;
    if (bready) begin
      step;
      chk("bvalid_clr", a_bvalid, 64'd0);
    end
  endtask

  initial begin
    rst_main_sync = 1'b1;
    awvalid = 1'b0; awaddr = 32'h0;
    wvalid  = 1'b0; wdata  = 32'h0; wstrb = 4'h0;
    bready  = 1'b1;
    arvalid = 1'b0; araddr = 32'h0;
    rready  = 1'b1;
    reg_in  = 256'h0;
    reg_in[95:64] = 32'hCAFE_F00D;
    vdip    = 16'h0;
    repeat (3) step;
    rst_main_sync = 1'b0;
    step;

    // Reset state
    chk("rst_bvalid", a_bvalid, 64'd0);
    chk("rst_rvalid", a_rvalid, 64'd0);
    chk("rst_rdata", a_rdata, 64'd0);
    chk("rst_reg_q", a_reg_q[63:0], 64'd0);
    chk("rst_wr_pulse", a_wr_pulse, 64'd0);
    chk("rst_vled", a_vled, 64'd0);
    chk("rst_awready", a_awready, 64'd1);
    chk("rst_wready", a_wready, 64'd1);
    chk("rst_arready", a_arready, 64'd1);

    // AW two cycles ahead of W
    awvalid = 1'b1; awaddr = 32'h0000_0500;
    step;
    awvalid = 1'b0;
    chk("aw_slot_full", a_awready, 64'd0);
    chk("w_slot_open", a_wready, 64'd1);
    step;
    wvalid = 1'b1; wdata = 32'h0000_6162; wstrb = 4'hF;
    step;
    wvalid = 1'b0;
    chk("t1_bvalid_commit", a_bvalid, 64'd0);
    step;
    chk("t1_bvalid", a_bvalid, 64'd1);
    chk("t1_bresp", a_bresp, 64'd0);
    chk("t1_reg_q", a_reg_q[31:0], 64'h6162);
    chk("t1_wr_pulse", a_wr_pulse, 64'h01);
    step;
    chk("t1_bvalid_clr", a_bvalid, 64'd0);
    chk("t1_wr_pulse_clr", a_wr_pulse, 64'h00);
    do_read(32'h0000_0500);
    chk("t1_rdata_a", rd_a, 64'h0000_6162);
    chk("t1_rdata_b_upper", rd_b, 64'h0000_4142);
    chk("t1_rresp", rr_a, 64'd0);

    // Upper-case read view on reg 0 of instance b
    do_write_same(32'h0000_0500, 32'h7A61_5B41, 4'hF);
    chk("t2_bresp_b", br_b, 64'd0);
    do_read(32'h0000_0500);
    chk("t2_rdata_a", rd_a, 64'h7A61_5B41);
    chk("t2_rdata_b", rd_b, 64'h5A41_5B41);
    chk("t2_rresp_b", rr_b, 64'd0);

    // W before AW, single-byte strobe
    do_write_same(32'h0000_0500, 32'h1122_3344, 4'hF);
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b0010;
    step;
    wvalid = 1'b0;
    chk("t3_wready_full", a_wready, 64'd0);
    chk("t3_awready_open", a_awready, 64'd1);
    step;
    awvalid = 1'b1; awaddr = 32'h0000_0500;
    step;
    awvalid = 1'b0;
    chk("t3_pulse_early", a_wr_pulse, 64'h00);
    step;
    chk("t3_reg_q", a_reg_q[31:0], 64'h1122_FF44);
    chk("t3_wr_pulse", a_wr_pulse, 64'h01);
    chk("t3_bvalid", a_bvalid, 64'd1);
    step;
    chk("t3_wr_pulse_1cyc", a_wr_pulse, 64'h00);

    // Decode errors and RO register
    do_read(32'h0000_0520);
    chk("err_rd_idx_data", rd_a, 64'hDEAD_BEEF);
    chk("err_rd_idx_resp", rr_a, 64'd3);
    do_read(32'h0000_04FC);
    chk("err_rd_low_resp", rr_a, 64'd3);
    do_write_same(32'h0000_0502, 32'h1234_5678, 4'hF);
    chk("err_wr_unaligned", br_a, 64'd3);
    chk("err_wr_nochange", a_reg_q[31:0], 64'h1122_FF44);
    do_write_same(32'h0000_0508, 32'h1234_5678, 4'hF);
    chk("rw_wr_resp_a", br_a, 64'd0);
    chk("ro_wr_resp_b", br_b, 64'd2);
    chk("rw_reg_q_a", a_reg_q[95:64], 64'h1234_5678);
    chk("ro_reg_q_b", b_reg_q[95:64], 64'h0);
    do_read(32'h0000_0508);
    chk("rw_rd_a", rd_a, 64'h1234_5678);
    chk("ro_rd_b", rd_b, 64'hCAFE_F00D);
    do_write_same(32'h0000_050C, 32'hFFFF_FFFF, 4'h0);
    chk("strb0_bresp", br_a, 64'd0);
    chk("strb0_no_pulse", wp_a, 64'h00);
    chk("strb0_nochange", a_reg_q[127:96], 64'h0);

    // B backpressure with concurrent read; VLED
    vdip   = 16'h0FF0;
    bready = 1'b0;
    do_write_same(32'h0000_0504, 32'h0000_A5A5, 4'hF);
    chk("bp_bresp", br_a, 64'd0);
    for (int i = 0; i < 10; i++) begin
      step;
      chk("bp_awready", a_awready, 64'd0);
      chk("bp_wready", a_wready, 64'd0);
      chk("bp_bvalid", a_bvalid, 64'd1);
      chk("bp_bresp_hold", a_bresp, 64'd0);
    end
    do_read(32'h0000_0504);
    chk("bp_rd", rd_a, 64'h0000_A5A5);
    chk("bp_bvalid_still", a_bvalid, 64'd1);
    bready = 1'b1;
    step;
    chk("bp_bvalid_clr", a_bvalid, 64'd0);
    chk("bp_awready_reopen", a_awready, 64'd1);
    chk("vled", a_vled, 64'h05A0);

    // Reset with AW and AR pending, W absent
    awvalid = 1'b1; awaddr = 32'h0000_0500;
    arvalid = 1'b1; araddr = 32'h0000_0500;
    step;
    awvalid = 1'b0;
    arvalid = 1'b0;
    chk("mid_aw_pending", a_awready, 64'd0);
    rst_main_sync = 1'b1;
    step;
    rst_main_sync = 1'b0;
    step;
    chk("mid_bvalid", a_bvalid, 64'd0);
    chk("mid_rvalid", a_rvalid, 64'd0);
    chk("mid_rdata", a_rdata, 64'd0);
    chk("mid_reg_q", a_reg_q[63:0], 64'd0);
    chk("mid_vled", a_vled, 64'd0);
    chk("mid_wr_pulse", a_wr_pulse, 64'd0);
    chk("mid_awready", a_awready, 64'd1);
    chk("mid_arready", a_arready, 64'd1);
    wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF;
    step;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mid_no_bvalid", a_bvalid, 64'd0);
      chk("mid_no_rvalid", a_rvalid, 64'd0);
    end
    chk("mid_reg_untouched", a_reg_q[31:0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
